// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and data memory (slave).
// Variable-latency request/acknowledge protocol. The request and its address, data and
// byte enables stay stable until the master samples the acknowledge.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// RISC-V memory-access pipeline stage.
// Accepts one instruction from execute, runs loads/stores over the request/ack data bus,
// aligns store lanes, extracts and extends load data, and retires one result to write-back.
// Optional feature macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus
// and retire with the misalign flag set; without it the low address bits are ignored.
module mem_access_stage (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [31:0]               alu_result,
  input  logic [31:0]               write_data,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [1:0]                size,
  input  logic                      load_unsigned,
  input  logic [4:0]                rd,
  input  logic                      reg_write,
  mem_access_stage_if.master        dmem,
  output logic                      wb_valid,
  output logic [31:0]               wb_result,
  output logic [4:0]                wb_rd,
  output logic                      wb_reg_write,
  output logic                      misalign
);

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t      r_state;
  logic        r_req, r_we;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_pend_addr;       // full address: store result / lane select
  logic [1:0]  r_pend_size;
  logic        r_pend_unsigned;
  logic [4:0]  r_pend_rd;
  logic        r_pend_reg_write;
  logic        r_wb_valid, r_wb_reg_write, r_misalign;
  logic [31:0] r_wb_result;
  logic [4:0]  r_wb_rd;

  logic        w_accept, w_is_mem, w_misaligned;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_load_data;

  assign ex_ready = (r_state == S_IDLE) && !reset;
  assign w_accept = ex_valid && ex_ready;
  assign w_is_mem = mem_read || mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  // Half needs an even address, word (size 10 or 11) a 4-byte aligned one.
  assign w_misaligned = w_is_mem &&
                        (((size == 2'b01) && alu_result[0]) ||
                         (size[1] && (alu_result[1:0] != 2'b00)));
`else
  assign w_misaligned = 1'b0;
`endif

  // Store lane alignment: enables from the low address bits, data replicated across lanes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_st_be    = 4'b1111;
    w_st_wdata = write_data;
    case (size)
      2'b00: begin
        w_st_be    = 4'b0001 << alu_result[1:0];
        w_st_wdata = {4{write_data[7:0]}};
      end
      2'b01: begin
        w_st_be    = alu_result[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{write_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction: pick the addressed byte/half of the returned word and extend it.
  always_comb begin
    w_ld_byte = dmem.dmem_rdata[7:0];
    case (r_pend_addr[1:0])
      2'b01:   w_ld_byte = dmem.dmem_rdata[15:8];
      2'b10:   w_ld_byte = dmem.dmem_rdata[23:16];
      2'b11:   w_ld_byte = dmem.dmem_rdata[31:24];
      default: ;
    endcase
    w_ld_half = r_pend_addr[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (r_pend_size)
      2'b00:   w_load_data = {{24{~r_pend_unsigned & w_ld_byte[7]}}, w_ld_byte};
      2'b01:   w_load_data = {{16{~r_pend_unsigned & w_ld_half[15]}}, w_ld_half};
      default: w_load_data = dmem.dmem_rdata;
    endcase
  end

  // Stage FSM: IDLE accepts and retires ALU ops/traps, BUS holds the request until ack.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      r_state          <= S_IDLE;
      r_req            <= 1'b0;
      r_we             <= 1'b0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_be             <= '0;
      r_pend_addr      <= '0;
      r_pend_size      <= '0;
      r_pend_unsigned  <= 1'b0;
      r_pend_rd        <= '0;
      r_pend_reg_write <= 1'b0;
      r_wb_valid       <= 1'b0;
      r_wb_result      <= '0;
      r_wb_rd          <= '0;
      r_wb_reg_write   <= 1'b0;
      r_misalign       <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_misaligned) begin
              r_wb_valid     <= 1'b1;
              r_misalign     <= 1'b1;
              r_wb_result    <= alu_result;
              r_wb_rd        <= rd;
              r_wb_reg_write <= 1'b0;
            end else if (w_is_mem) begin
              r_state          <= S_BUS;
              r_req            <= 1'b1;
              r_we             <= mem_write;
              r_addr           <= {alu_result[31:2], 2'b00};
              r_wdata          <= w_st_wdata;
              r_be             <= mem_write ? w_st_be : 4'b0000;
              r_pend_addr      <= alu_result;
              r_pend_size      <= size;
              r_pend_unsigned  <= load_unsigned;
              r_pend_rd        <= rd;
              r_pend_reg_write <= mem_write ? 1'b0 : reg_write;
            end else begin
              r_wb_valid     <= 1'b1;
              r_wb_result    <= alu_result;
              r_wb_rd        <= rd;
              r_wb_reg_write <= reg_write;
            end
          end
        end
        S_BUS: begin
          if (dmem.dmem_ack) begin
            r_state        <= S_IDLE;
            r_req          <= 1'b0;
            r_wb_valid     <= 1'b1;
            r_wb_result    <= r_we ? r_pend_addr : w_load_data;
            r_wb_rd        <= r_pend_rd;
            r_wb_reg_write <= r_pend_reg_write;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;
  assign dmem.dmem_be    = r_be;
  assign wb_valid        = r_wb_valid;
  assign wb_result       = r_wb_result;
  assign wb_rd           = r_wb_rd;
  assign wb_reg_write    = r_wb_reg_write;
  assign misalign        = r_misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: randomized instruction stream plus the
// directed scenarios, a reference model computing bus and write-back expectations,
// a data-memory responder with random latency, and a write-back monitor/scoreboard.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] alu_result = '0, write_data = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [1:0]  size = '0;
  logic        load_unsigned = 1'b0;
  logic [4:0]  rd = '0;
  logic        reg_write = 1'b0;
  logic        wb_valid, wb_reg_write, misalign;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;

  mem_access_stage_if dmem_bus();

  mem_access_stage dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .load_unsigned(load_unsigned),
    .rd(rd), .reg_write(reg_write),
    .dmem(dmem_bus),
    .wb_valid(wb_valid), .wb_result(wb_result), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        is_mem;
    int          cyc;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cyc;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];

  int checks = 0;
  int failures = 0;
  bit mem_busy = 1'b0;
  int last_ack_cyc = -10;
  bit hold = 1'b0;
  bit force_ack = 1'b0;
  int fixed_lat = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_2000) return 32'h80FF_1234;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 4'(32'd1 << (a % 4));
    if (sz == 2'd1) return (((a / 2) % 2) != 0) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'd0) return {24'h0, wd[7:0]} * 32'h0101_0101;
    if (sz == 2'd1) return {16'h0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (word >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
      return v;
    end
    if (sz == 2'd1) begin
      v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
      return v;
    end
    return word;
  endfunction

  // Present one instruction, wait (bounded) for acceptance, record expectations.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic rdn,
                       input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [4:0] r, input logic rw);
    int      budget;
    bit      is_mem, mis;
    wb_exp_t  we_;
    bus_exp_t be_;
    @(negedge clk);
    ex_valid = 1'b1; alu_result = a; write_data = wd; mem_read = rdn; mem_write = wr;
    size = sz; load_unsigned = uns; rd = r; reg_write = rw;
    budget = 0;
    while (!ex_ready) begin
      @(negedge clk);
      budget++;
      if (budget > 50) begin
        check("accept_timeout", 32'd0, 32'd1);
        ex_valid = 1'b0;
        return;
      end
    end
    is_mem = rdn || wr;
    mis = TRAP_EN && is_mem && (((sz == 2'd1) && (a % 2 != 0)) || ((sz >= 2'd2) && (a % 4 != 0)));
    we_.rd = r; we_.cyc = cyc + 1; we_.mis = mis; we_.is_mem = is_mem && !mis;
    if (!is_mem) begin
      we_.result = a; we_.rw = rw;
    end else if (mis) begin
      we_.result = a; we_.rw = 1'b0;
    end else begin
      be_.addr  = a & ~32'd3;
      be_.we    = wr;
      be_.be    = wr ? ref_be(a, sz) : 4'h0;
      be_.wdata = ref_wdata(wd, sz);
      be_.cyc   = cyc + 1;
      bus_q.push_back(be_);
      we_.result = wr ? a : ref_load(mem_word(a & ~32'd3), a, sz, uns);
      we_.rw     = wr ? 1'b0 : rw;
    end
    wb_q.push_back(we_);
    @(posedge clk);
    #1;
    if (we_.is_mem) mem_busy = 1'b1;
    ex_valid = 1'b0;
  endtask

  // ---------------- data-memory responder ----------------
  initial begin : slave
    bit       active;
    int       cnt, lat;
    bus_exp_t cur;
    active = 1'b0; cnt = 0; lat = 0;
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_bus.dmem_ack = 1'b0;
      dmem_bus.dmem_rdata = $urandom;
      if (reset) begin
        active = 1'b0;
      end else if (dmem_bus.dmem_req) begin
        if (!active) begin
          if (bus_q.size() == 0) begin
            check("unexpected_dmem_req", 32'd1, 32'd0);
          end else begin
            cur = bus_q.pop_front();
            check("req_start_cycle", cyc, cur.cyc);
            active = 1'b1; cnt = 0;
            lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
          end
        end
        if (active) begin
          check("dmem_addr", dmem_bus.dmem_addr, cur.addr);
          check("dmem_we", 32'(dmem_bus.dmem_we), 32'(cur.we));
          check("dmem_be", 32'(dmem_bus.dmem_be), 32'(cur.be));
          if (cur.we) check("dmem_wdata", dmem_bus.dmem_wdata, cur.wdata);
          if (!hold && cnt == lat) begin
            dmem_bus.dmem_ack = 1'b1;
            dmem_bus.dmem_rdata = mem_word(dmem_bus.dmem_addr);
            last_ack_cyc = cyc;
            active = 1'b0;
          end
          cnt++;
        end
      end else begin
        active = 1'b0;
        // A stray ack while the stage is idle must be ignored.
        if (!hold && $urandom_range(0, 3) == 0) dmem_bus.dmem_ack = 1'b1;
      end
      if (hold) dmem_bus.dmem_ack = force_ack;
    end
  end

  // ---------------- write-back monitor ----------------
  initial begin : monitor
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (wb_valid) begin
          if (wb_q.size() == 0) begin
            check("unexpected_wb_valid", 32'd1, 32'd0);
          end else begin
            e = wb_q.pop_front();
            check("wb_result", wb_result, e.result);
            check("wb_rd", 32'(wb_rd), 32'(e.rd));
            check("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
            check("misalign", 32'(misalign), 32'(e.mis));
            check("wb_cycle", cyc, e.is_mem ? last_ack_cyc + 1 : e.cyc);
            if (e.is_mem) mem_busy = 1'b0;
          end
        end else begin
          check("misalign_idle", 32'(misalign), 32'd0);
        end
        check("ex_ready", 32'(ex_ready), 32'(!mem_busy));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [31:0] a;
    logic [1:0]  sz;
    int          kind;
    logic        wr, rdn;
    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ex_ready", 32'(ex_ready), 32'd0);
    check("rst_dmem_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("rst_dmem_we", 32'(dmem_bus.dmem_we), 32'd0);
    check("rst_dmem_be", 32'(dmem_bus.dmem_be), 32'd0);
    check("rst_dmem_addr", dmem_bus.dmem_addr, 32'd0);
    check("rst_dmem_wdata", dmem_bus.dmem_wdata, 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_result", wb_result, 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    reset = 1'b0;
    #1;
    check("ex_ready_after_reset", 32'(ex_ready), 32'd1);

    // Back-to-back ALU results 5, 6, 7.
    issue(32'd5, '0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd1, 1'b1);
    issue(32'd6, '0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd2, 1'b1);
    issue(32'd7, '0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd3, 1'b1);

    // Store byte 0xA5 to 0x1003 with a three-cycle bus access.
    fixed_lat = 2;
    issue(32'h1003, 32'h0000_00A5, 1'b0, 1'b1, 2'd0, 1'b0, 5'd4, 1'b1);
    fixed_lat = -1;

    // Loads from the word at 0x2000 (0x80FF1234).
    issue(32'h2002, '0, 1'b1, 1'b0, 2'd1, 1'b0, 5'd5, 1'b1);
    issue(32'h2002, '0, 1'b1, 1'b0, 2'd1, 1'b1, 5'd6, 1'b1);
    issue(32'h2001, '0, 1'b1, 1'b0, 2'd0, 1'b1, 5'd7, 1'b1);
    fixed_lat = 0;
    issue(32'h2000, '0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd8, 1'b1);
    issue(32'h2003, '0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd9, 1'b1);
    fixed_lat = -1;

    // Word load at 0x3001: traps with the macro, otherwise aligned access at 0x3000.
    issue(32'h3001, '0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd10, 1'b1);
    repeat (6) @(negedge clk);

    // Reset in the middle of a bus access; the late ack must be ignored.
    hold = 1'b1;
    issue(32'h4000, '0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd11, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wb_q.delete();
    mem_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("req_after_reset", 32'(dmem_bus.dmem_req), 32'd0);
    check("wb_valid_after_reset", 32'(wb_valid), 32'd0);
    check("wb_result_after_reset", wb_result, 32'd0);
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_wb_on_late_ack", 32'(wb_valid), 32'd0);
    end
    hold = 1'b0;

    // Randomized instruction stream.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      kind = int'($urandom_range(0, 2));
      wr   = (kind == 2);
      rdn  = (kind == 1) || ((kind == 2) && $urandom_range(0, 1) == 1);
      sz   = 2'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
      issue(a, $urandom, rdn, wr, sz, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    // Drain outstanding results.
    for (int i = 0; i < 100; i++) begin
      if (wb_q.size() == 0 && bus_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_wb_queue", 32'(wb_q.size()), 32'd0);
    check("drain_bus_queue", 32'(bus_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access pipeline stage of the RISC-V core. It sits directly downstream of the execute stage and consumes its ALU result (address or pass-through value) and store data. It drives a variable-latency request/acknowledge data-memory bus, aligns store bytes and extracts/extends load data, and hands one result per instruction to write-back. It back-pressures execute with a ready signal while a bus access is outstanding.

## Interface
- No parameters; widths fixed at 32-bit data/address, 5-bit register index.
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage accepts this cycle; transfer when ex_valid && ex_ready
- alu_result  in  32  memory address, or result for non-memory ops
- write_data  in  32  store data (rs2)
- mem_read  in  1  load
- mem_write  in  1  store; priority over mem_read
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- load_unsigned  in  1  zero-extend loaded byte/half
- rd  in  5  destination register
- reg_write  in  1  instruction writes rd
- dmem_req  out  1  bus request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables (stores; 0 on loads)
- dmem_ack  in  1  access complete; rdata valid this cycle for loads
- dmem_rdata  in  32  load word
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_result  out  32  value for rd
- wb_rd  out  5  destination register
- wb_reg_write  out  1  qualify register write
- misalign  out  1  one-cycle misaligned-access flag (see Configuration)

## Operation
- States: IDLE, BUS. ex_ready = (state==IDLE) && !reset.
- IDLE, accept non-memory op: next cycle wb_valid=1, wb_result=alu_result, wb_rd/wb_reg_write copied; stay IDLE (1 instr/cycle).
- IDLE, accept load/store: latch request; go BUS.
- BUS: dmem_req=1 with dmem_addr/we/be/wdata stable every cycle until dmem_ack sampled 1; then IDLE.
- Store lanes: byte be=1<<addr[1:0], wdata={4{b}}; half be=addr[1]?1100:0011, wdata={2{h}}; word be=1111.
- Load: select byte addr[1:0] or half addr[1]; sign-extend unless load_unsigned; word unchanged. wb_result = extended data, wb_reg_write = reg_write.
- Store retires with wb_valid=1, wb_reg_write=0, wb_result=alu_result.
- dmem_ack while IDLE is ignored.
- Reset: state IDLE; dmem_req, dmem_we, dmem_be, wb_valid, wb_reg_write, misalign = 0; dmem_addr, dmem_wdata, wb_result, wb_rd = 0. Reset during BUS abandons the access; dmem_req low from the cycle after the reset edge; a late ack is ignored.

## Timing
- Non-memory: accept in cycle N -> wb_valid in N+1.
- Memory: accept in N -> dmem_req high from N+1; ack in cycle M>=N+1 -> wb_valid in M+1, ex_ready high in M+1 (next accept possible at M+1).
- Zero-wait bus (ack in N+1): wb_valid at N+2, load-use throughput one access per 2 cycles.
- wb_valid never high two cycles for one instruction; all outputs registered except ex_ready.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no bus access; stays IDLE; next cycle wb_valid=1, misalign=1, wb_reg_write=0, wb_result=faulting address.
- Undefined: misalign tied 0; low address bits ignored (half uses addr[1], word forced aligned) and the access proceeds normally.

## Test plan
- Reset held 2 cycles -> all outputs 0, ex_ready 0 during reset, 1 the cycle after release.
- Back-to-back ALU ops results 5, 6, 7 -> wb_valid 3 consecutive cycles, wb_result 5, 6, 7, no dmem_req.
- Store byte 0xA5 to 0x1003, ack after 3 cycles -> dmem_addr 0x1000, be 1000, wdata 0xA5A5A5A5 stable 3 cycles, ex_ready 0 until the cycle after ack.
- Load half signed at 0x2002, rdata 0x80FF1234 -> wb_result 0xFFFF80FF; unsigned -> 0x000080FF; lbu at 0x2001 -> 0x00000012.
- Reset asserted mid-BUS, ack arrives afterward -> dmem_req low after reset edge, no wb_valid.
- With MEM_MISALIGN_TRAP_EN, word load at 0x3001 -> no dmem_req, misalign=1 and wb_valid=1 next cycle, wb_result 0x3001; without macro -> access at 0x3000, misalign 0.
